// File: rtl/al_phy_dpram_rd_if.sv
`default_nettype none
// ============================================================================
// Module  : al_phy_dpram_rd_if
// Brief   : Slice RAMW-mode write bus (mode, strobe, address, data).
// Revision: 1.0 - initial release
// ============================================================================
interface al_phy_dpram_rd_if;
    logic       dpram_mode;
    logic       dpram_we;
    logic [3:0] dpram_waddr;
    logic [3:0] dpram_di;

    modport master (
        output dpram_mode,
        output dpram_we,
        output dpram_waddr,
        output dpram_di
    );

    modport slave (
        input  dpram_mode,
        input  dpram_we,
        input  dpram_waddr,
        input  dpram_di
    );
endinterface
`default_nettype wire

// File: rtl/al_phy_dpram_rd.sv
`default_nettype none
// ============================================================================
// Module  : al_phy_dpram_rd
// Brief   : 16x4 distributed RAM store fed by a slice RAMW write bus; one-cycle
//           capture then commit, combinational and registered read ports.
//           Optional macro AL_DPRAM_BYPASS_EN forwards a pending write to f.
// Revision: 1.0 - initial release
// ============================================================================
module al_phy_dpram_rd #(
    parameter logic [15:0] INIT_LUT0 = 16'h0000,
    parameter logic [15:0] INIT_LUT1 = 16'h0000,
    parameter logic [15:0] INIT_LUT2 = 16'h0000,
    parameter logic [15:0] INIT_LUT3 = 16'h0000,
    parameter string       REGSET    = "RESET",
    parameter string       CEMUX     = "1"
) (
    input  wire logic        clk,
    input  wire logic        sr,
    al_phy_dpram_rd_if.slave wr,
    input  wire logic [3:0]  raddr,
    input  wire logic        ce,
    output logic      [3:0]  f,
    output logic      [3:0]  q,
    output logic             wpend
);

    function automatic logic [15:0][3:0] f_mem_init();
        logic [15:0][3:0] init;
        for (int k = 0; k < 16; k++) begin
            init[k] = {INIT_LUT3[k], INIT_LUT2[k], INIT_LUT1[k], INIT_LUT0[k]};
        end
        return init;
    endfunction

    localparam logic [15:0][3:0] c_mem_init = f_mem_init();
    localparam logic [3:0]       c_q_rst    = (REGSET == "SET") ? 4'hF : 4'h0;
    localparam bit               c_ce_pin   = (CEMUX == "CE");
    localparam bit               c_ce_inv   = (CEMUX == "INV");
    localparam bit               c_ce_one   = (CEMUX == "1");

    // Array has no reset: sr must never disturb stored contents.
    logic [15:0][3:0] mem_q = c_mem_init;
    logic [15:0][3:0] mem_d;

    logic       wpend_q, wpend_d;
    logic [3:0] waddr_q, waddr_d;
    logic [3:0] di_q,    di_d;
    logic [3:0] q_q,     q_d;
    logic       w_capture;
    logic       w_q_en;
    logic [3:0] w_rdata;

    always_comb begin
        w_capture = wr.dpram_mode & wr.dpram_we;
        wpend_d   = w_capture;
        waddr_d   = w_capture ? wr.dpram_waddr : waddr_q;
        di_d      = w_capture ? wr.dpram_di    : di_q;

        mem_d = mem_q;
        if (wpend_q) begin
            mem_d[waddr_q] = di_q;
        end

`ifdef AL_DPRAM_BYPASS_EN
        w_rdata = (wpend_q && (waddr_q == raddr)) ? di_q : mem_q[raddr];
`else
        w_rdata = mem_q[raddr];
`endif

        w_q_en = (c_ce_pin & ce) | (c_ce_inv & ~ce) | c_ce_one;
        q_d    = w_q_en ? w_rdata : q_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge sr) begin
        if (sr) begin
            wpend_q <= 1'b0;
            waddr_q <= 4'h0;
            di_q    <= 4'h0;
            q_q     <= c_q_rst;
        end else begin
            wpend_q <= wpend_d;
            waddr_q <= waddr_d;
            di_q    <= di_d;
            q_q     <= q_d;
        end
    end

    assign f     = w_rdata;
    assign q     = q_q;
    assign wpend = wpend_q;

endmodule
`default_nettype wire

// File: tb/tb_al_phy_dpram_rd.sv
`default_nettype none
// ============================================================================
// Module  : tb_al_phy_dpram_rd
// Brief   : Directed self-checking bench for al_phy_dpram_rd.
// Revision: 1.0 - initial release
// ============================================================================
module tb_al_phy_dpram_rd;

`ifdef AL_DPRAM_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    // Initial image: mem[0]=1, mem[3]=4, mem[5]=2, mem[9]=8, others 0.
    localparam logic [15:0] c_lut0 = 16'h0001;
    localparam logic [15:0] c_lut1 = 16'h0020;
    localparam logic [15:0] c_lut2 = 16'h0008;
    localparam logic [15:0] c_lut3 = 16'h0200;

    logic       clk = 1'b0;
    logic       sr;
    logic [3:0] raddr;
    logic       ce;
    logic [3:0] f;
    logic [3:0] q;
    logic       wpend;
    int         checks = 0;
    int         errors = 0;

    al_phy_dpram_rd_if wr_if ();

    al_phy_dpram_rd #(
        .INIT_LUT0 (c_lut0),
        .INIT_LUT1 (c_lut1),
        .INIT_LUT2 (c_lut2),
        .INIT_LUT3 (c_lut3),
        .REGSET    ("SET"),
        .CEMUX     ("CE")
    ) u_dut (
        .clk   (clk),
        .sr    (sr),
        .wr    (wr_if.slave),
        .raddr (raddr),
        .ce    (ce),
        .f     (f),
        .q     (q),
        .wpend (wpend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic m, input logic w, input logic [3:0] a, input logic [3:0] d);
        wr_if.dpram_mode  = m;
        wr_if.dpram_we    = w;
        wr_if.dpram_waddr = a;
        wr_if.dpram_di    = d;
    endtask

    initial begin
        sr    = 1'b1;
        ce    = 1'b0;
        raddr = 4'h0;
        drive_wr(1'b0, 1'b0, 4'h0, 4'h0);
        #3;
        chk("rst_q_set",   q,            4'hF);
        chk("rst_wpend",   {3'b0, wpend}, 4'h0);
        chk("init_f0",     f,            4'h1);
        raddr = 4'h1;
        #1;
        chk("init_f1",     f,            4'h0);

        @(negedge clk);
        sr = 1'b0;

        // Basic write to address 5 (old value 2)
        raddr = 4'h5;
        drive_wr(1'b1, 1'b1, 4'h5, 4'hA);
        #1;
        chk("bw_f_before", f, 4'h2);
        edge_step();
        drive_wr(1'b1, 1'b0, 4'h5, 4'hA);
        chk("bw_wpend_hi", {3'b0, wpend}, 4'h1);
        chk("bw_f_e0",     f, c_byp ? 4'hA : 4'h2);
        edge_step();
        chk("bw_wpend_lo", {3'b0, wpend}, 4'h0);
        chk("bw_f_e1",     f, 4'hA);
        chk("ce0_q_hold",  q, 4'hF);
        edge_step();
        chk("ce0_q_hold2", q, 4'hF);

        ce = 1'b1;
        edge_step();
        chk("ce1_q_load",  q, 4'hA);

        // Back-to-back writes, reading address 3 (old value 4)
        raddr = 4'h3;
        drive_wr(1'b1, 1'b1, 4'h3, 4'h1);
        edge_step();
        chk("b2b_q_e0",    q, 4'h4);
        chk("b2b_f_e0",    f, c_byp ? 4'h1 : 4'h4);
        drive_wr(1'b1, 1'b1, 4'h3, 4'h2);
        edge_step();
        chk("b2b_q_e1",    q, c_byp ? 4'h1 : 4'h4);
        chk("b2b_f_e1",    f, c_byp ? 4'h2 : 4'h1);
        drive_wr(1'b1, 1'b1, 4'h4, 4'h7);
        edge_step();
        chk("b2b_q_e2",    q, c_byp ? 4'h2 : 4'h1);
        chk("b2b_f_e2",    f, 4'h2);
        drive_wr(1'b1, 1'b0, 4'h0, 4'h0);
        edge_step();
        chk("b2b_mem3",    f, 4'h2);
        raddr = 4'h4;
        #1;
        chk("b2b_mem4",    f, 4'h7);

        // Mode gating
        raddr = 4'h2;
        drive_wr(1'b0, 1'b1, 4'h2, 4'hF);
        edge_step();
        chk("mg_wpend",    {3'b0, wpend}, 4'h0);
        edge_step();
        chk("mg_mem2",     f, 4'h0);
        drive_wr(1'b1, 1'b1, 4'h2, 4'h6);
        edge_step();
        drive_wr(1'b0, 1'b1, 4'h2, 4'h6);
        chk("mg_cap_wpend", {3'b0, wpend}, 4'h1);
        edge_step();
        chk("mg_drop_wpend", {3'b0, wpend}, 4'h0);
        chk("mg_drop_commit", f, 4'h6);

        // Reset with a write pending to address 9 (old value 8)
        raddr = 4'h9;
        drive_wr(1'b1, 1'b1, 4'h9, 4'hC);
        edge_step();
        drive_wr(1'b0, 1'b0, 4'h0, 4'h0);
        chk("rw_wpend_cap", {3'b0, wpend}, 4'h1);
        sr = 1'b1;
        #1;
        chk("rw_wpend_rst", {3'b0, wpend}, 4'h0);
        chk("rw_q_rst",     q, 4'hF);
        chk("rw_f_rst",     f, 4'h8);
        edge_step();
        edge_step();
        sr = 1'b0;
        #1;
        chk("rw_mem9_kept", f, 4'h8);
        chk("rw_q_after",   q, 4'hF);
        edge_step();
        chk("rw_mem9_still", f, 4'h8);

        // First capture after reset release
        drive_wr(1'b1, 1'b1, 4'h9, 4'h3);
        edge_step();
        drive_wr(1'b0, 1'b0, 4'h0, 4'h0);
        chk("post_wpend",   {3'b0, wpend}, 4'h1);
        edge_step();
        chk("post_mem9",    f, 4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
